// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - state, opcode and select encodings for uc_multiciclo
// UC_JAL_EN adds the JAL state to the enum.
package uc_pkg;

    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        RESET_ST = 4'd0,
        FETCH    = 4'd1,
        PC_INC   = 4'd2,
        DECODE   = 4'd3,
        R_EXEC   = 4'd4,
        I_EXEC   = 4'd5,
        MEM_ADDR = 4'd6,
        LD_MEM   = 4'd7,
        LD_WB    = 4'd8,
        SD_MEM   = 4'd9,
        BRANCH   = 4'd10,
        LUI_EXEC = 4'd11,
        WB_ALU   = 4'd12,
        TRAP     = 4'd13
`ifdef UC_JAL_EN
        ,
        JAL      = 4'd14
`endif
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [2:0] ALU_PASSB = 3'd0;
    localparam logic [2:0] ALU_ADD   = 3'd1;
    localparam logic [2:0] ALU_SUB   = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_4      = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

endpackage

// File: rtl/uc_decoder.sv
// rtl/uc_decoder.sv - maps IR to the post-DECODE dispatch state or TRAP
// UC_JAL_EN enables dispatch of opcode 1101111 to JAL.
module uc_decoder
    import uc_pkg::*;
(
    input  logic [31:0] ir,
    output state_t      dec_state,
    output logic [2:0]  dec_alu_op,
    output logic        dec_br_ne,
    output logic        dec_store
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_ir;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign funct7    = ir[31:25];
    assign unused_ir = ^{ir[24:15], ir[11:7]};

    always_comb begin
        dec_state  = TRAP;
        dec_alu_op = ALU_ADD;
        dec_br_ne  = 1'b0;
        dec_store  = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct3 == F3_ADD && funct7 == F7_BASE) begin
                    dec_state = R_EXEC;
                end else if (funct3 == F3_ADD && funct7 == F7_SUB) begin
                    dec_state  = R_EXEC;
                    dec_alu_op = ALU_SUB;
                end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
                    dec_state  = R_EXEC;
                    dec_alu_op = ALU_AND;
                end
            end
            OP_IMM:   if (funct3 == F3_ADD) dec_state = I_EXEC;
            OP_LOAD:  if (funct3 == F3_D) dec_state = MEM_ADDR;
            OP_STORE: begin
                if (funct3 == F3_D) begin
                    dec_state = MEM_ADDR;
                    dec_store = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    dec_state = BRANCH;
                end else if (funct3 == F3_BNE) begin
                    dec_state = BRANCH;
                    dec_br_ne = 1'b1;
                end
            end
            OP_LUI: dec_state = LUI_EXEC;
`ifdef UC_JAL_EN
            OP_JAL: dec_state = JAL;
`endif
            default: dec_state = TRAP;
        endcase
    end

endmodule

// File: rtl/uc_multiciclo.sv
// rtl/uc_multiciclo.sv - multicycle Moore control unit with memory wait states and trap
// UC_JAL_EN adds the JAL execution state.
module uc_multiciclo
    import uc_pkg::*;
#(
    parameter int MEM_LAT   = 1,
    parameter int ALU_SEL_W = 3,
    parameter int STATE_W   = 7
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [31:0]          IR,
    input  logic                 IGUAL,
    output logic                 PC_WRITE,
    output logic                 IR_WRITE,
    output logic                 INST_MEM_RD,
    output logic                 DATA_MEM_RD,
    output logic                 DATA_MEM_WR,
    output logic                 LOAD_A,
    output logic                 LOAD_B,
    output logic                 LOAD_ALUOUT,
    output logic                 LOAD_MDR,
    output logic                 REG_WRITE,
    output logic                 RESET_WIRE,
    output logic                 EXCECAO,
    output logic                 ALU_SRCA,
    output logic [1:0]           ALU_SRCB,
    output logic [ALU_SEL_W-1:0] ALU_SEL,
    output logic [1:0]           MEM_TO_REG,
    output logic                 PC_SRC,
    output logic [STATE_W-1:0]   ESTADO_ATUAL
);

    localparam int              CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             br_ne_q, br_ne_d;
    logic             store_q, store_d;
    logic [2:0]       alu_sel;
    logic             last_beat;

    state_t     dec_state;
    logic [2:0] dec_alu_op;
    logic       dec_br_ne;
    logic       dec_store;

    uc_decoder u_decoder (
        .ir         (IR),
        .dec_state  (dec_state),
        .dec_alu_op (dec_alu_op),
        .dec_br_ne  (dec_br_ne),
        .dec_store  (dec_store)
    );

    assign last_beat    = (cnt_q == CNT_LAST);
    assign ALU_SEL      = ALU_SEL_W'(alu_sel);
    assign ESTADO_ATUAL = STATE_W'(state_q);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= RESET_ST;
            cnt_q    <= '0;
            alu_op_q <= ALU_ADD;
            br_ne_q  <= 1'b0;
            store_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alu_op_q <= alu_op_d;
            br_ne_q  <= br_ne_d;
            store_q  <= store_d;
        end
    end

    // The counter idles at zero, so every wait state is entered with a cleared count.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        alu_op_d    = alu_op_q;
        br_ne_d     = br_ne_q;
        store_d     = store_q;
        PC_WRITE    = 1'b0;
        IR_WRITE    = 1'b0;
        INST_MEM_RD = 1'b0;
        DATA_MEM_RD = 1'b0;
        DATA_MEM_WR = 1'b0;
        LOAD_A      = 1'b0;
        LOAD_B      = 1'b0;
        LOAD_ALUOUT = 1'b0;
        LOAD_MDR    = 1'b0;
        REG_WRITE   = 1'b0;
        RESET_WIRE  = 1'b0;
        EXCECAO     = 1'b0;
        ALU_SRCA    = 1'b0;
        ALU_SRCB    = SRCB_B;
        alu_sel     = ALU_PASSB;
        MEM_TO_REG  = M2R_ALUOUT;
        PC_SRC      = PCSRC_ALU;
        case (state_q)
            RESET_ST: begin
                RESET_WIRE = 1'b1;
                state_d    = FETCH;
            end
            FETCH: begin
                INST_MEM_RD = 1'b1;
                if (last_beat) begin
                    IR_WRITE = 1'b1;
                    state_d  = PC_INC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PC_INC: begin
                PC_WRITE = 1'b1;
                ALU_SRCB = SRCB_4;
                alu_sel  = ALU_ADD;
                state_d  = DECODE;
            end
            DECODE: begin
                // Operation details are captured here so later IR changes are ignored.
                LOAD_A      = 1'b1;
                LOAD_B      = 1'b1;
                LOAD_ALUOUT = 1'b1;
                ALU_SRCB    = SRCB_IMM_SH;
                alu_sel     = ALU_ADD;
                state_d     = dec_state;
                alu_op_d    = dec_alu_op;
                br_ne_d     = dec_br_ne;
                store_d     = dec_store;
            end
            R_EXEC: begin
                ALU_SRCA    = 1'b1;
                alu_sel     = alu_op_q;
                LOAD_ALUOUT = 1'b1;
                state_d     = WB_ALU;
            end
            I_EXEC: begin
                ALU_SRCA    = 1'b1;
                ALU_SRCB    = SRCB_IMM;
                alu_sel     = ALU_ADD;
                LOAD_ALUOUT = 1'b1;
                state_d     = WB_ALU;
            end
            MEM_ADDR: begin
                ALU_SRCA    = 1'b1;
                ALU_SRCB    = SRCB_IMM;
                alu_sel     = ALU_ADD;
                LOAD_ALUOUT = 1'b1;
                state_d     = store_q ? SD_MEM : LD_MEM;
            end
            LD_MEM: begin
                DATA_MEM_RD = 1'b1;
                if (last_beat) begin
                    LOAD_MDR = 1'b1;
                    state_d  = LD_WB;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LD_WB: begin
                REG_WRITE  = 1'b1;
                MEM_TO_REG = M2R_MDR;
                state_d    = FETCH;
            end
            SD_MEM: begin
                DATA_MEM_WR = 1'b1;
                if (last_beat) begin
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BRANCH: begin
                ALU_SRCA = 1'b1;
                alu_sel  = ALU_SUB;
                if (IGUAL ^ br_ne_q) begin
                    PC_WRITE = 1'b1;
                    PC_SRC   = PCSRC_ALUOUT;
                end
                state_d = FETCH;
            end
            LUI_EXEC: begin
                ALU_SRCB    = SRCB_IMM;
                alu_sel     = ALU_PASSB;
                LOAD_ALUOUT = 1'b1;
                state_d     = WB_ALU;
            end
            WB_ALU: begin
                REG_WRITE = 1'b1;
                state_d   = FETCH;
            end
`ifdef UC_JAL_EN
            JAL: begin
                REG_WRITE  = 1'b1;
                MEM_TO_REG = M2R_PC;
                PC_WRITE   = 1'b1;
                PC_SRC     = PCSRC_ALUOUT;
                state_d    = FETCH;
            end
`endif
            TRAP: begin
                EXCECAO = 1'b1;
            end
            default: state_d = TRAP;
        endcase
    end

endmodule

// File: tb/tb_uc_multiciclo.sv
// tb/tb_uc_multiciclo.sv - bench for uc_multiciclo at MEM_LAT 1..4 (honours UC_JAL_EN)
module tb_uc_multiciclo;

    localparam int ND = 4;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       inst_mem_rd;
        logic       data_mem_rd;
        logic       data_mem_wr;
        logic       load_a;
        logic       load_b;
        logic       load_aluout;
        logic       load_mdr;
        logic       reg_write;
        logic       reset_wire;
        logic       excecao;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] alu_sel;
        logic [1:0] m2r;
        logic       pc_src;
        logic       in_reset;
    } outv_t;

    typedef enum int {C_ADD, C_SUB, C_AND, C_ADDI, C_LD, C_SD, C_BEQ, C_BNE, C_LUI, C_JAL, C_ILL} cls_t;

    typedef struct {
        int          k;
        logic [31:0] ir;
        logic        igual;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] ir_v [ND];
    logic        igual_v [ND];
    outv_t       o_v [ND];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        logic       pw, iw, imr, dmr, dmw, la, lb, lao, lm, rw, rwire, exc, sa, ps;
        logic [1:0] sb, mr;
        logic [2:0] as;
        logic [6:0] est;

        uc_multiciclo #(.MEM_LAT(g + 1), .ALU_SEL_W(3), .STATE_W(7)) u_dut (
            .CLK          (clk),
            .RESET_N      (rst_n),
            .IR           (ir_v[g]),
            .IGUAL        (igual_v[g]),
            .PC_WRITE     (pw),
            .IR_WRITE     (iw),
            .INST_MEM_RD  (imr),
            .DATA_MEM_RD  (dmr),
            .DATA_MEM_WR  (dmw),
            .LOAD_A       (la),
            .LOAD_B       (lb),
            .LOAD_ALUOUT  (lao),
            .LOAD_MDR     (lm),
            .REG_WRITE    (rw),
            .RESET_WIRE   (rwire),
            .EXCECAO      (exc),
            .ALU_SRCA     (sa),
            .ALU_SRCB     (sb),
            .ALU_SEL      (as),
            .MEM_TO_REG   (mr),
            .PC_SRC       (ps),
            .ESTADO_ATUAL (est)
        );

        assign o_v[g] = {pw, iw, imr, dmr, dmw, la, lb, lao, lm, rw, rwire, exc,
                         sa, sb, as, mr, ps, (est == 7'd0)};
    end

    function automatic cls_t classify(logic [31:0] ir);
        logic [6:0] op = ir[6:0];
        logic [2:0] f3 = ir[14:12];
        logic [6:0] f7 = ir[31:25];
        if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) return C_ADD;
        if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) return C_SUB;
        if (op == 7'h33 && f3 == 3'd7 && f7 == 7'h00) return C_AND;
        if (op == 7'h13 && f3 == 3'd0) return C_ADDI;
        if (op == 7'h03 && f3 == 3'd3) return C_LD;
        if (op == 7'h23 && f3 == 3'd3) return C_SD;
        if (op == 7'h63 && f3 == 3'd0) return C_BEQ;
        if (op == 7'h63 && f3 == 3'd1) return C_BNE;
        if (op == 7'h37) return C_LUI;
`ifdef UC_JAL_EN
        if (op == 7'h6F) return C_JAL;
`endif
        return C_ILL;
    endfunction

    function automatic int ilen(int L, cls_t c);
        case (c)
            C_LD:                return 2 * L + 4;
            C_SD:                return 2 * L + 3;
            C_BEQ, C_BNE, C_JAL: return L + 3;
            C_ILL:               return L + 2 + 20;
            default:             return L + 4;
        endcase
    endfunction

    // Expected outputs on cycle cyc (0-based) of an instruction, from the timing rules.
    function automatic outv_t model(int L, cls_t c, logic ig, int cyc);
        outv_t o = '0;
        int    e;
        logic  taken;
        if (cyc < L) begin
            o.inst_mem_rd = 1'b1;
            o.ir_write    = (cyc == L - 1);
            return o;
        end
        if (cyc == L) begin
            o.pc_write = 1'b1; o.srcb = 2'd1; o.alu_sel = 3'd1;
            return o;
        end
        if (cyc == L + 1) begin
            o.load_a = 1'b1; o.load_b = 1'b1; o.load_aluout = 1'b1;
            o.srcb = 2'd3; o.alu_sel = 3'd1;
            return o;
        end
        e = cyc - L - 2;
        case (c)
            C_ADD, C_SUB, C_AND: begin
                if (e == 0) begin
                    o.srca = 1'b1; o.load_aluout = 1'b1;
                    o.alu_sel = (c == C_ADD) ? 3'd1 : (c == C_SUB) ? 3'd2 : 3'd3;
                end else o.reg_write = 1'b1;
            end
            C_ADDI: begin
                if (e == 0) begin
                    o.srca = 1'b1; o.srcb = 2'd2; o.alu_sel = 3'd1; o.load_aluout = 1'b1;
                end else o.reg_write = 1'b1;
            end
            C_LUI: begin
                if (e == 0) begin
                    o.srcb = 2'd2; o.load_aluout = 1'b1;
                end else o.reg_write = 1'b1;
            end
            C_LD, C_SD: begin
                if (e == 0) begin
                    o.srca = 1'b1; o.srcb = 2'd2; o.alu_sel = 3'd1; o.load_aluout = 1'b1;
                end else if (c == C_SD) begin
                    o.data_mem_wr = 1'b1;
                end else if (e <= L) begin
                    o.data_mem_rd = 1'b1;
                    o.load_mdr    = (e == L);
                end else begin
                    o.reg_write = 1'b1; o.m2r = 2'd1;
                end
            end
            C_BEQ, C_BNE: begin
                taken = (c == C_BEQ) ? ig : !ig;
                o.srca = 1'b1; o.alu_sel = 3'd2;
                o.pc_write = taken; o.pc_src = taken;
            end
            C_JAL: begin
                o.reg_write = 1'b1; o.m2r = 2'd2; o.pc_write = 1'b1; o.pc_src = 1'b1;
            end
            default: o.excecao = 1'b1;
        endcase
        return o;
    endfunction

    function automatic outv_t rst_exp();
        outv_t o = '0;
        o.reset_wire = 1'b1;
        o.in_reset   = 1'b1;
        return o;
    endfunction

    task automatic check(int k, outv_t exp, string name);
        checks++;
        if (o_v[k] !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h want %h", name, k, o_v[k], exp);
        end
    endtask

    // Two low clock edges, then the single RESET_ST cycle with RESET_N high.
    task automatic do_reset(int k);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk) check(k, rst_exp(), "reset_low");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk) check(k, rst_exp(), "reset_release");
    endtask

    // IR is only valid in the DECODE cycle and IGUAL only in the BRANCH cycle; junk elsewhere.
    task automatic run_instr(int k, logic [31:0] ir, logic ig, int len, string name);
        int   L = k + 1;
        cls_t c = classify(ir);
        for (int cyc = 0; cyc < len; cyc++) begin
            @(posedge clk); #1;
            ir_v[k]    = (cyc == L + 1) ? ir : $urandom;
            igual_v[k] = (cyc == L + 2) ? ig : 1'($urandom);
            @(negedge clk);
            check(k, model(L, c, ig, cyc), name);
        end
    endtask

    function automatic logic [31:0] gen_ir();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 10))
            0:  return {7'h00, r[24:15], 3'd0, r[11:7], 7'h33};
            1:  return {7'h20, r[24:15], 3'd0, r[11:7], 7'h33};
            2:  return {7'h00, r[24:15], 3'd7, r[11:7], 7'h33};
            3:  return {r[31:15], 3'd0, r[11:7], 7'h13};
            4:  return {r[31:15], 3'd3, r[11:7], 7'h03};
            5:  return {r[31:15], 3'd3, r[11:7], 7'h23};
            6:  return {r[31:15], 3'd0, r[11:7], 7'h63};
            7:  return {r[31:15], 3'd1, r[11:7], 7'h63};
            8:  return {r[31:7], 7'h37};
            9:  return {r[31:7], 7'h6F};
            default: return r;
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        int   prev;
        logic [31:0] rir;
        logic        rig;

        for (int i = 0; i < ND; i++) begin
            ir_v[i]    = 32'h0;
            igual_v[i] = 1'b0;
        end

        tbl.push_back('{2, 32'h002081B3, 1'b0, 7});
        tbl.push_back('{2, 32'h402081B3, 1'b0, 7});
        tbl.push_back('{2, 32'h0020F1B3, 1'b0, 7});
        tbl.push_back('{1, 32'h0000B183, 1'b0, 8});
        tbl.push_back('{1, 32'h00313023, 1'b0, 7});
        tbl.push_back('{0, 32'h00500093, 1'b0, 5});
        tbl.push_back('{0, 32'h123450B7, 1'b0, 5});
        tbl.push_back('{0, 32'h00208063, 1'b1, 4});
        tbl.push_back('{0, 32'h00209063, 1'b1, 4});
        tbl.push_back('{0, 32'h0000B183, 1'b0, 6});
        tbl.push_back('{0, 32'h00313023, 1'b0, 5});
        tbl.push_back('{3, 32'h0000B183, 1'b0, 12});
        tbl.push_back('{3, 32'h00209063, 1'b0, 7});
        tbl.push_back('{3, 32'h00313023, 1'b0, 11});
        tbl.push_back('{3, 32'h002081B3, 1'b0, 8});

        prev = -1;
        foreach (tbl[i]) begin
            if (tbl[i].k != prev) do_reset(tbl[i].k);
            prev = tbl[i].k;
            run_instr(tbl[i].k, tbl[i].ir, tbl[i].igual, tbl[i].lat, $sformatf("tbl%0d", i));
        end

        // Illegal opcode: trap held, then reset recovers.
        do_reset(2);
        run_instr(2, 32'h0000007F, 1'b0, 3 + 2 + 20, "trap_hold");
        do_reset(2);
        run_instr(2, 32'h002081B3, 1'b0, 7, "post_trap");

        // Reset during the second SD_MEM cycle aborts the store.
        do_reset(3);
        for (int cyc = 0; cyc <= 8; cyc++) begin
            @(posedge clk); #1;
            ir_v[3] = (cyc == 5) ? 32'h00313023 : $urandom;
            if (cyc == 8) rst_n = 1'b0;
            @(negedge clk);
            check(3, model(4, C_SD, 1'b0, cyc), "sd_pre_abort");
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk) check(3, rst_exp(), "sd_abort");
        run_instr(3, 32'h00313023, 1'b0, 11, "sd_after_abort");
        run_instr(3, 32'h002081B3, 1'b0, 8, "add_after_sd");

        // JAL: executes when enabled, otherwise traps.
        do_reset(1);
`ifdef UC_JAL_EN
        run_instr(1, 32'h000000EF, 1'b0, 5, "jal");
        run_instr(1, 32'h002081B3, 1'b0, 6, "after_jal");
`else
        run_instr(1, 32'h000000EF, 1'b0, 2 + 2 + 5, "jal_trap");
        do_reset(1);
`endif

        for (int k = 0; k < ND; k++) begin
            do_reset(k);
            for (int n = 0; n < 30; n++) begin
                rir = gen_ir();
                rig = 1'($urandom);
                run_instr(k, rir, rig, ilen(k + 1, classify(rir)), "rand");
                if (classify(rir) == C_ILL) do_reset(k);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
